// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: drives the PC, issues word fetches to instruction memory and queues returned words for decode.
// Optional misaligned-PC blocking is compiled in by defining FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTST       = 2,
    parameter logic [31:0] INST_START_FROM = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [1:0]  cmd,
    output logic [31:0] load_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);
    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_INC  = 2'd1;
    localparam logic [1:0] CMD_LOAD = 2'd2;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   discard_q, discard_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   aq_wr_q, aq_wr_d;
    logic [AW-1:0]   aq_rd_q, aq_rd_d;
    logic [31:0]     fifo_data_q [DEPTH];
    logic [31:0]     fifo_data_d [DEPTH];
    logic [31:0]     fifo_pc_q [DEPTH];
    logic [31:0]     fifo_pc_d [DEPTH];
    logic [31:0]     aq_q [MAX_OUTST];
    logic [31:0]     aq_d [MAX_OUTST];

    logic rsp_fire, req_fire, redirect, pop, push, credit_ok, align_block;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
`endif

    function automatic logic [AW-1:0] aq_inc(input logic [AW-1:0] p);
        return (32'(p) == MAX_OUTST - 1) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        outst_d     = outst_q;
        discard_d   = discard_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        aq_wr_d     = aq_wr_q;
        aq_rd_d     = aq_rd_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        aq_d        = aq_q;
        cmd         = CMD_NONE;
        load_pc     = INST_START_FROM;
        push        = 1'b0;

        rsp_fire  = rsp_valid && (outst_q != '0);
        redirect  = rst && redirect_valid && (state_q != IDLE);
        pop       = inst_valid && inst_ready;
        credit_ok = (32'(count_q) + 32'(outst_q) < 32'(DEPTH)) && (32'(outst_q) < 32'(MAX_OUTST));

`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d  = misalign_q;
        align_block = (state_q == RUN) && (pc[1:0] != 2'b00);
        if (rst && align_block) begin
            misalign_d = 1'b1;
        end
`else
        align_block = 1'b0;
`endif

        req_valid = rst && (state_q == RUN) && credit_ok && !redirect_valid && !align_block;
        req_fire  = req_valid && req_ready;

        if (req_fire) begin
            cmd           = CMD_INC;
            aq_d[aq_wr_q] = pc;
            aq_wr_d       = aq_inc(aq_wr_q);
        end
        if (rsp_fire) begin
            aq_rd_d = aq_inc(aq_rd_q);
        end
        outst_d = outst_q + OW'(req_fire) - OW'(rsp_fire);

        // A response landing in the redirect cycle is stale too, so it never reaches the flushed FIFO.
        if (redirect) begin
            cmd       = CMD_LOAD;
            load_pc   = redirect_addr;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            discard_d = outst_q - OW'(rsp_fire);
            state_d   = (discard_d != '0) ? DRAIN : RUN;
        end else begin
            push = rsp_fire && (discard_q == '0);
            if (push) begin
                fifo_data_d[wr_ptr_q] = rsp_data;
                fifo_pc_d[wr_ptr_q]   = aq_q[aq_rd_q];
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - OW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            case (state_q)
                IDLE:    state_d = RUN;
                DRAIN:   if (discard_d == '0) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            aq_wr_q   <= '0;
            aq_rd_q   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            aq_wr_q   <= aq_wr_d;
            aq_rd_q   <= aq_rd_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the counters and pointers above.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_pc_q   <= fifo_pc_d;
        aq_q        <= aq_d;
    end

    assign req_addr   = pc;
    assign inst_valid = (count_q != '0);
    assign inst_data  = fifo_data_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    assert property (@(posedge clk) disable iff (!rst) !(rsp_valid && (outst_q == '0)));
    assert property (@(posedge clk) disable iff (!rst)
        (32'(count_q) <= 32'(DEPTH)) && (32'(outst_q) <= 32'(MAX_OUTST)) && (discard_q <= outst_q));

endmodule
